// File: rtl/vproc_mem_responder.sv
// Word-addressed memory slave for the VProc bus master: programmable wait states,
// byte-enable writes, one-cycle RDAck/WRAck pulses and an Update/UpdateResponse follower.
module vproc_mem_responder #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int WAIT_STATES    = 0,
  parameter int BURST_WAIT     = 0
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [31:0] Addr,
  input  logic [3:0]  BE,
  input  logic        WE,
  input  logic        RD,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        WRAck,
  output logic        RDAck,
  input  logic [11:0] Burst,
  input  logic        BurstFirst,
  input  logic        BurstLast,
  input  logic        Update,
  output logic        UpdateResponse,
  output logic [15:0] BeatCount
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam logic [7:0] WS_L = 8'(WAIT_STATES);
  localparam logic [7:0] BW_L = 8'(BURST_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]                be_q, be_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      wr_q, wr_d;
  logic                      wr_ack_q, wr_ack_d;
  logic                      rd_ack_q, rd_ack_d;
  logic [15:0]               beat_q, beat_d;
  logic [31:0]               rdata_q;

  logic                      req;
  logic                      burst_cont;
  logic [7:0]                wait_load;
  logic                      enter_ack;
  logic                      mem_we;
  logic [31:0]               lane_rd;

  // Only the low index bits address the array; BurstLast carries no behaviour.
  logic unused_inputs;
  assign unused_inputs = ^{Addr[31:MEM_ADDR_WIDTH], BurstLast};

  assign req        = WE | RD;
  assign burst_cont = (Burst != 12'd0) && !BurstFirst;
  assign wait_load  = burst_cont ? BW_L : WS_L;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    beat_d    = beat_q;
    enter_ack = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d   = Addr[MEM_ADDR_WIDTH-1:0];
          be_d    = BE;
          wdata_d = WrData;
          wr_d    = WE;
          if (wait_load == 8'd0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            cnt_d   = wait_load - 8'd1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d   = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK: begin
        // VProc retires its command with an NBA on this same edge, so inputs are stale here.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_ack) begin
      wr_ack_d = wr_d;
      rd_ack_d = !wr_d;
      beat_d   = beat_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      wr_q     <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      beat_q   <= 16'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      beat_q   <= beat_d;
      if (enter_ack && !wr_d) begin
        rdata_q <= lane_rd;
      end
    end
  end

  // nReset gates the write so a zero-wait request seen during reset cannot touch the array.
  assign mem_we = enter_ack && wr_d && nReset;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge Clk) begin
      if (mem_we && be_d[gi]) begin
        lane_mem[idx_d] <= wdata_d[8*gi +: 8];
      end
    end

    assign lane_rd[8*gi +: 8] = lane_mem[idx_d];
  end

  assign RdData         = rdata_q;
  assign WRAck          = wr_ack_q;
  assign RDAck          = rd_ack_q;
  assign BeatCount      = beat_q;
  assign UpdateResponse = Update;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Bench for vproc_mem_responder: three instances with different wait settings,
// table-driven accesses checked through a scoreboard queue, plus reset and delta-loop sequences.
module tb_vproc_mem_responder;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset [ND];
  logic [31:0] addr   [ND];
  logic [3:0]  be     [ND];
  logic        we     [ND];
  logic        rd     [ND];
  logic [31:0] wdata  [ND];
  logic [31:0] rdata  [ND];
  logic        wrack  [ND];
  logic        rdack  [ND];
  logic [11:0] burst  [ND];
  logic        bfirst [ND];
  logic        blast  [ND];
  logic        upd    [ND];
  logic        updr   [ND];
  logic [15:0] beats  [ND];

  // Instance 0: no waits; 1: WAIT_STATES=3, BURST_WAIT=1; 2: WAIT_STATES=5.
  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int WS = (gi == 0) ? 0 : ((gi == 1) ? 3 : 5);
    localparam int BW = (gi == 1) ? 1 : 0;
    vproc_mem_responder #(
      .MEM_ADDR_WIDTH(12),
      .WAIT_STATES   (WS),
      .BURST_WAIT    (BW)
    ) u_dut (
      .Clk           (clk),
      .nReset        (nreset[gi]),
      .Addr          (addr[gi]),
      .BE            (be[gi]),
      .WE            (we[gi]),
      .RD            (rd[gi]),
      .WrData        (wdata[gi]),
      .RdData        (rdata[gi]),
      .WRAck         (wrack[gi]),
      .RDAck         (rdack[gi]),
      .Burst         (burst[gi]),
      .BurstFirst    (bfirst[gi]),
      .BurstLast     (blast[gi]),
      .Update        (upd[gi]),
      .UpdateResponse(updr[gi]),
      .BeatCount     (beats[gi])
    );
  end

  typedef struct {
    int          dut;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [11:0] burst;
    bit          first;
    bit          last;
    int          exp_lat;
    bit          exp_wack;
    logic [31:0] exp_rdata;
    int          exp_beat;
  } vec_t;

  vec_t tbl  [$];
  vec_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t V(input int d, input bit w, input bit r, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] dat, input logic [11:0] bl,
                             input bit f, input bit l, input int lat, input bit ew,
                             input logic [31:0] er, input int eb);
    vec_t v;
    v.dut = d; v.wr = w; v.rd = r; v.addr = a; v.be = b; v.data = dat;
    v.burst = bl; v.first = f; v.last = l;
    v.exp_lat = lat; v.exp_wack = ew; v.exp_rdata = er; v.exp_beat = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
    n_tests++;
    if (act_v !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act_v, req_v);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   lat;
    bit   seen;
    bit   got_w;
    bit   got_both;
    int   d;
    d = v.dut;
    @(negedge clk);
    addr[d]   = v.addr;
    be[d]     = v.be;
    wdata[d]  = v.data;
    burst[d]  = v.burst;
    bfirst[d] = v.first;
    blast[d]  = v.last;
    we[d]     = v.wr;
    rd[d]     = v.rd;
    sb_q.push_back(v);
    @(posedge clk);
    lat = 0; seen = 1'b0; got_w = 1'b0; got_both = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      we[d] = 1'b0;
      rd[d] = 1'b0;
      if (wrack[d] || rdack[d]) begin
        seen     = 1'b1;
        got_w    = wrack[d];
        got_both = wrack[d] && rdack[d];
      end
    end
    e = sb_q.pop_front();
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: dut %0d addr 0x%08h got no ack, required ack within %0d cycles",
               d, e.addr, e.exp_lat);
    end else begin
      check("ack_kind_wr", {31'd0, got_w}, {31'd0, e.exp_wack});
      check("single_ack_kind", {31'd0, got_both}, 32'd0);
      check("ack_latency", lat, e.exp_lat);
      check("rdata", rdata[d], e.exp_rdata);
      check("beat_count", {16'd0, beats[d]}, e.exp_beat);
      @(negedge clk);
      check("ack_pulse_width", {31'd0, wrack[d] | rdack[d]}, 32'd0);
    end
    $display("[TB] dut%0d %s addr=0x%08h be=%h data=0x%08h burst=%0d first=%0b lat=%0d rdata=0x%08h beats=%0d",
             d, v.wr ? "WR" : "RD", v.addr, v.be, v.data, v.burst, v.first, lat, rdata[d], beats[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [15:0] beat_before;

    // dut0: no waits
    tbl.push_back(V(0, 1, 0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 12'd0, 0, 0, 1, 1, 32'h0000_0000, 1));
    tbl.push_back(V(0, 0, 1, 32'h0000_0010, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'hDEAD_BEEF, 2));
    tbl.push_back(V(0, 1, 0, 32'h0000_0020, 4'hF, 32'h1122_3344, 12'd0, 0, 0, 1, 1, 32'hDEAD_BEEF, 3));
    tbl.push_back(V(0, 1, 0, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 12'd0, 0, 0, 1, 1, 32'hDEAD_BEEF, 4));
    tbl.push_back(V(0, 0, 1, 32'h0000_0020, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'h11BB_33DD, 5));
    tbl.push_back(V(0, 1, 0, 32'h0000_1005, 4'hF, 32'h5A5A_5A5A, 12'd0, 0, 0, 1, 1, 32'h11BB_33DD, 6));
    tbl.push_back(V(0, 0, 1, 32'h0000_0005, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'h5A5A_5A5A, 7));
    tbl.push_back(V(0, 1, 0, 32'h0000_0FFF, 4'hF, 32'h0F0F_0F0F, 12'd2, 1, 0, 1, 1, 32'h5A5A_5A5A, 8));
    tbl.push_back(V(0, 1, 0, 32'h0000_1000, 4'hF, 32'h1234_5678, 12'd2, 0, 1, 1, 1, 32'h5A5A_5A5A, 9));
    tbl.push_back(V(0, 0, 1, 32'h0000_0FFF, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'h0F0F_0F0F, 10));
    tbl.push_back(V(0, 0, 1, 32'h0000_0000, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'h1234_5678, 11));
    tbl.push_back(V(0, 0, 1, 32'h0000_7FFF, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'h0F0F_0F0F, 12));
    tbl.push_back(V(0, 1, 1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, 12'd0, 0, 0, 1, 1, 32'h0F0F_0F0F, 13));
    tbl.push_back(V(0, 0, 1, 32'h0000_0040, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'hCAFE_F00D, 14));
    tbl.push_back(V(0, 1, 0, 32'h0000_0040, 4'h0, 32'h0000_0000, 12'd0, 0, 0, 1, 1, 32'hCAFE_F00D, 15));
    tbl.push_back(V(0, 0, 1, 32'h0000_0040, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'hCAFE_F00D, 16));
    tbl.push_back(V(0, 1, 0, 32'h0000_0040, 4'h8, 32'h9900_0000, 12'd0, 0, 0, 1, 1, 32'hCAFE_F00D, 17));
    tbl.push_back(V(0, 0, 1, 32'h0000_0040, 4'hF, 32'h0,         12'd0, 0, 0, 1, 0, 32'h99FE_F00D, 18));
    // dut1: WAIT_STATES=3 (latency 4), BURST_WAIT=1 (latency 2)
    tbl.push_back(V(1, 1, 0, 32'h0000_0100, 4'hF, 32'hA000_0000, 12'd4, 1, 0, 4, 1, 32'h0, 1));
    tbl.push_back(V(1, 1, 0, 32'h0000_0101, 4'hF, 32'hA000_0001, 12'd4, 0, 0, 2, 1, 32'h0, 2));
    tbl.push_back(V(1, 1, 0, 32'h0000_0102, 4'hF, 32'hA000_0002, 12'd4, 0, 0, 2, 1, 32'h0, 3));
    tbl.push_back(V(1, 1, 0, 32'h0000_0103, 4'hF, 32'hA000_0003, 12'd4, 0, 1, 2, 1, 32'h0, 4));
    tbl.push_back(V(1, 0, 1, 32'h0000_0100, 4'hF, 32'h0,         12'd0, 0, 0, 4, 0, 32'hA000_0000, 5));
    tbl.push_back(V(1, 0, 1, 32'h0000_0101, 4'hF, 32'h0,         12'd4, 1, 0, 4, 0, 32'hA000_0001, 6));
    tbl.push_back(V(1, 0, 1, 32'h0000_0102, 4'hF, 32'h0,         12'd4, 0, 0, 2, 0, 32'hA000_0002, 7));
    tbl.push_back(V(1, 0, 1, 32'h0000_0103, 4'hF, 32'h0,         12'd4, 0, 1, 2, 0, 32'hA000_0003, 8));
    // dut2: WAIT_STATES=5 (latency 6); preload 0x30 with zero
    tbl.push_back(V(2, 1, 0, 32'h0000_0030, 4'hF, 32'h0000_0000, 12'd0, 0, 0, 6, 1, 32'h0, 1));

    for (int d = 0; d < ND; d++) begin
      nreset[d] = 1'b0; addr[d] = '0; be[d] = '0; we[d] = 1'b0; rd[d] = 1'b0;
      wdata[d] = '0; burst[d] = '0; bfirst[d] = 1'b0; blast[d] = 1'b0; upd[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("reset_wrack", {31'd0, wrack[d]}, 32'd0);
      check("reset_rdack", {31'd0, rdack[d]}, 32'd0);
      check("reset_rdata", rdata[d], 32'd0);
      check("reset_beats", {16'd0, beats[d]}, 32'd0);
      nreset[d] = 1'b1;
    end

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
    end

    // Request held high with no waits: the ACK edge ignores it, so acks land every other cycle.
    @(negedge clk);
    addr[0] = 32'h0000_0010; burst[0] = '0; bfirst[0] = 1'b0; blast[0] = 1'b0; rd[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("b2b_rdack", {31'd0, rdack[0]}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 0) check("b2b_rdata", rdata[0], 32'hDEAD_BEEF);
    end
    rd[0] = 1'b0;
    check("b2b_beats", {16'd0, beats[0]}, 32'd20);
    $display("[TB] dut0 held RD x4 beats=%0d", beats[0]);

    // Reset two cycles into a 5-wait write: the write must be lost.
    @(negedge clk);
    addr[2] = 32'h0000_0030; wdata[2] = 32'hFFFF_FFFF; be[2] = 4'hF; burst[2] = '0; we[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    nreset[2] = 1'b0;
    #1;
    check("rst_mid_wrack", {31'd0, wrack[2]}, 32'd0);
    check("rst_mid_rdack", {31'd0, rdack[2]}, 32'd0);
    check("rst_mid_beats", {16'd0, beats[2]}, 32'd0);
    upd[2] = ~upd[2];
    #1;
    check("rst_update_follow", {31'd0, updr[2]}, {31'd0, upd[2]});
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset[2] = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (wrack[2] || rdack[2]) acks++;
    end
    check("rst_no_late_ack", acks, 32'd0);
    $display("[TB] dut2 reset mid-write acks_after=%0d beats=%0d", acks, beats[2]);
    run_vec(V(2, 0, 1, 32'h0000_0030, 4'hF, 32'h0, 12'd0, 0, 0, 6, 0, 32'h0000_0000, 1));

    // Delta loop with an idle bus.
    beat_before = beats[0];
    acks = 0;
    for (int t = 0; t < 50; t++) begin
      upd[0] = ~upd[0];
      #1;
      check("update_follow", {31'd0, updr[0]}, {31'd0, upd[0]});
      if (wrack[0] || rdack[0]) acks++;
      #2;
    end
    check("update_no_acks", acks, 32'd0);
    check("update_beats_still", {16'd0, beats[0]}, {16'd0, beat_before});
    $display("[TB] dut0 50 Update toggles acks=%0d beats=%0d", acks, beats[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
